// File: rtl/beam_trigger_scaler.sv
// Per-beam trigger rate scaler: masks the 2xNBEAMS trigger flags, counts
// them in saturating counters over a fixed gate period, double-buffers the
// totals into a holding array for addressed readout, and provides a
// registered per-threshold OR of the masked flags.

// One scaler channel: live saturating counter plus its holding register.
module bts_lane #(
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hit,
  input  logic                term,
  output logic [CNT_BITS-1:0] hold
);
  logic [CNT_BITS-1:0] live;
  logic [CNT_BITS-1:0] live_nxt;

  // Saturating increment; an all-ones counter stays put.
  always_comb begin
    live_nxt = live;
    if (hit && (live != '1)) live_nxt = live + CNT_BITS'(1);
  end

  // On the terminal edge the holding register takes the value live would
  // have reached, so a hit in the terminal cycle lands in the closing period.
  always_ff @(posedge clk) begin
    if (rst) begin
      live <= '0;
      hold <= '0;
    end else if (term) begin
      live <= '0;
      hold <= live_nxt;
    end else begin
      live <= live_nxt;
    end
  end
endmodule

module beam_trigger_scaler #(
  parameter int NBEAMS    = 48,
  parameter int CNT_BITS  = 16,
  parameter int PERIOD    = 1250000,
  parameter int ADDR_BITS = $clog2(2*NBEAMS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [2*NBEAMS-1:0]   trig_i,
  input  logic [NBEAMS-1:0]     mask_i,
  input  logic [ADDR_BITS-1:0]  scal_addr_i,
  output logic [CNT_BITS-1:0]   scal_dat_o,
  output logic                  period_done_o,
  output logic [1:0]            trig_or_o
);
  localparam int NCH    = 2*NBEAMS;
  localparam int GATE_W = $clog2(PERIOD);

  logic [NCH-1:0]               trig_q;
  logic [GATE_W-1:0]            gate;
  logic                         term;
  logic [NCH-1:0][CNT_BITS-1:0] hold;
  logic [CNT_BITS-1:0]          rd;

  assign term = (gate == GATE_W'(PERIOD-1));

  // Input stage: mask applies to both thresholds of a beam.
  always_ff @(posedge clk_i) begin
    if (rst_i) trig_q <= '0;
    else       trig_q <= trig_i & {~mask_i, ~mask_i};
  end

  // Early trigger flag per threshold set, one register after trig_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) trig_or_o <= '0;
    else       trig_or_o <= {|trig_q[NBEAMS +: NBEAMS], |trig_q[0 +: NBEAMS]};
  end

  // Gate counter; the pulse marks the first cycle the new totals are visible.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gate          <= '0;
      period_done_o <= 1'b0;
    end else begin
      gate          <= term ? '0 : gate + GATE_W'(1);
      period_done_o <= term;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_lane
      bts_lane #(.CNT_BITS(CNT_BITS)) u_lane (
        .clk  (clk_i),
        .rst  (rst_i),
        .hit  (trig_q[g]),
        .term (term),
        .hold (hold[g])
      );
    end
  endgenerate

  // Address decode; out-of-range addresses match nothing and read zero.
  always_comb begin
    rd = '0;
    for (int i = 0; i < NCH; i++)
      if (scal_addr_i == ADDR_BITS'(i)) rd = hold[i];
  end

  // Registered readout; sees the pre-update holding value on an update edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) scal_dat_o <= '0;
    else       scal_dat_o <= rd;
  end
endmodule
